// File: rtl/mem_cell_mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_cell_mm_pkg
// Desc     : Shared mode and read/write opcode definitions for mem_cell_mm.
// Revision : 1.0 - initial release
// ============================================================================
package mem_cell_mm_pkg;

    typedef enum logic [2:0] {
        MODE_RAM  = 3'd0,
        MODE_FIFO = 3'd1,
        MODE_LIFO = 3'd2,
        MODE_RING = 3'd3
    } mode_e;

    localparam logic [1:0] RW_IDLE = 2'b00;
    localparam logic [1:0] RW_WR   = 2'b01;
    localparam logic [1:0] RW_RD   = 2'b10;
    localparam logic [1:0] RW_RDWR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mem_cell_mm_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_cell_mm_array
// Desc     : DEPTH x DATA_W register array, one write port, one registered
//            read port; a same-address read returns the pre-write word.
// Revision : 1.0 - initial release
// ============================================================================
module mem_cell_mm_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_cell_mm.sv
`default_nettype none
// ============================================================================
// Module   : mem_cell_mm
// Desc     : Multi-mode storage cell (RAM / FIFO / LIFO / overwrite ring)
//            with chip select, occupancy count and error strobe.
// Revision : 1.0 - initial release
// ============================================================================
module mem_cell_mm
    import mem_cell_mm_pkg::*;
#(
    parameter int         DATA_W  = 32,
    parameter int         DEPTH   = 8,
    parameter logic [2:0] CHIP_ID = 3'b001,
    parameter int         ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Din,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        mode_in,
    input  logic [2:0]        chip_en,
    input  logic [1:0]        rw,
    output logic [DATA_W-1:0] Dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    localparam logic [ADDR_W:0]   c_full_cnt = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one  = ADDR_W'(1);

    logic [2:0]        r_mode;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_dout_valid;
    logic              r_err;

    logic              w_sel;
    logic              w_flush;
    logic              w_queue_mode;
    logic              w_is_full;
    logic              w_is_empty;
    logic              w_wr_req;
    logic              w_rd_req;
    logic [ADDR_W-1:0] w_top;

    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic              w_re;
    logic [ADDR_W-1:0] w_raddr;
    logic [ADDR_W-1:0] w_nxt_wr;
    logic [ADDR_W-1:0] w_nxt_rd;
    logic [ADDR_W:0]   w_nxt_cnt;
    logic              w_err;

    assign w_flush      = (mode_in != r_mode);
    assign w_sel        = !reset && (chip_en == CHIP_ID) && !w_flush;
    assign w_queue_mode = (r_mode == MODE_FIFO) || (r_mode == MODE_LIFO) ||
                          (r_mode == MODE_RING);
    assign w_is_full    = (r_count == c_full_cnt);
    assign w_is_empty   = (r_count == '0);
    assign w_wr_req     = (rw == RW_WR) || (rw == RW_RDWR);
    assign w_rd_req     = (rw == RW_RD) || (rw == RW_RDWR);
    // Wraps to DEPTH-1 when full, which is exactly the top-of-stack slot.
    assign w_top        = r_count[ADDR_W-1:0] - c_ptr_one;

    always_comb begin
        w_rd_ok   = 1'b0;
        w_wr_ok   = 1'b0;
        w_we      = 1'b0;
        w_waddr   = '0;
        w_re      = 1'b0;
        w_raddr   = '0;
        w_nxt_wr  = r_wr_ptr;
        w_nxt_rd  = r_rd_ptr;
        w_nxt_cnt = r_count;
        w_err     = 1'b0;
        if (w_sel) begin
            case (r_mode)
                MODE_RAM: begin
                    w_we    = w_wr_req;
                    w_waddr = addr;
                    w_re    = w_rd_req;
                    w_raddr = addr;
                end
                MODE_FIFO, MODE_RING: begin
                    w_rd_ok = w_rd_req && !w_is_empty;
                    w_wr_ok = w_wr_req &&
                              (!w_is_full || w_rd_ok || (r_mode == MODE_RING));
                    if (w_rd_ok) begin
                        w_re     = 1'b1;
                        w_raddr  = r_rd_ptr;
                        w_nxt_rd = r_rd_ptr + c_ptr_one;
                    end
                    if (w_wr_ok) begin
                        w_we     = 1'b1;
                        w_waddr  = r_wr_ptr;
                        w_nxt_wr = r_wr_ptr + c_ptr_one;
                        // Ring overwrite: the oldest entry is discarded.
                        if (w_is_full && !w_rd_ok) begin
                            w_nxt_rd = r_rd_ptr + c_ptr_one;
                        end
                    end
                end
                MODE_LIFO: begin
                    w_rd_ok = w_rd_req && !w_is_empty;
                    w_wr_ok = w_wr_req && (!w_is_full || w_rd_ok);
                    if (w_rd_ok) begin
                        w_re    = 1'b1;
                        w_raddr = w_top;
                    end
                    if (w_wr_ok) begin
                        w_we    = 1'b1;
                        w_waddr = w_rd_ok ? w_top : r_count[ADDR_W-1:0];
                    end
                end
                default: begin
                    w_err = (rw != RW_IDLE);
                end
            endcase
            if (w_queue_mode) begin
                w_err = (w_rd_req && w_is_empty) || (w_wr_req && !w_wr_ok);
                if (w_wr_ok && !w_rd_ok && !w_is_full) begin
                    w_nxt_cnt = r_count + c_cnt_one;
                end else if (w_rd_ok && !w_wr_ok) begin
                    w_nxt_cnt = r_count - c_cnt_one;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode       <= MODE_RAM;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_dout_valid <= w_re;
            r_err        <= w_err;
            if (w_flush) begin
                r_mode   <= mode_in;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                r_wr_ptr <= w_nxt_wr;
                r_rd_ptr <= w_nxt_rd;
                r_count  <= w_nxt_cnt;
            end
        end
    end

    mem_cell_mm_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (Din),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (Dout)
    );

    assign dout_valid = r_dout_valid;
    assign err        = r_err;
    assign count      = r_count;
    assign full       = w_queue_mode && w_is_full;
    assign empty      = w_queue_mode && w_is_empty;

endmodule
`default_nettype wire

// File: tb/tb_mem_cell_mm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_cell_mm
// Desc     : Self-checking bench for mem_cell_mm against a queue/stack model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_cell_mm;

    localparam int DW = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] Din;
    logic [2:0]    addr;
    logic [2:0]    mode_in;
    logic [2:0]    chip_en;
    logic [1:0]    rw;
    logic [DW-1:0] Dout;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic [3:0]    count;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Model: logical contents as a circular queue (head + occupancy) or a stack.
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_valid [DEPTH];
    int            m_mode, m_head, m_cnt;
    logic [DW-1:0] e_dout;
    bit            e_known, e_dv, e_err;

    always #5 clk = ~clk;

    mem_cell_mm #(
        .DATA_W  (DW),
        .DEPTH   (DEPTH),
        .CHIP_ID (3'b001)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Din        (Din),
        .addr       (addr),
        .mode_in    (mode_in),
        .chip_en    (chip_en),
        .rw         (rw),
        .Dout       (Dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_read(input int idx);
        e_dout  = m_mem[idx];
        e_known = m_valid[idx];
        e_dv    = 1'b1;
    endtask

    task automatic m_write(input int idx, input logic [DW-1:0] d);
        m_mem[idx]   = d;
        m_valid[idx] = 1'b1;
    endtask

    task automatic model_step(input logic r, input logic [2:0] md, input logic [2:0] ce,
                              input logic [1:0] op, input logic [DW-1:0] d, input logic [2:0] a);
        bit rd_ok, wr_ok;
        e_dv  = 1'b0;
        e_err = 1'b0;
        if (r) begin
            m_mode = 0; m_head = 0; m_cnt = 0;
            e_dout = '0; e_known = 1'b1;
            return;
        end
        if (int'(md) != m_mode) begin
            m_mode = int'(md); m_head = 0; m_cnt = 0;
            return;
        end
        if (ce != 3'b001) return;
        if (m_mode == 0) begin
            if (op[1]) m_read(int'(a));
            if (op[0]) m_write(int'(a), d);
        end else if (m_mode <= 3) begin
            rd_ok = op[1] && (m_cnt > 0);
            if (m_mode == 2) wr_ok = op[0] && (m_cnt < DEPTH || rd_ok);
            else             wr_ok = op[0] && (m_cnt < DEPTH || rd_ok || m_mode == 3);
            e_err = (op[1] && m_cnt == 0) || (op[0] && !wr_ok);
            if (m_mode == 2) begin
                if (rd_ok) begin m_read(m_cnt - 1); m_cnt--; end
                if (wr_ok) begin m_write(m_cnt, d); m_cnt++; end
            end else begin
                if (rd_ok) begin
                    m_read(m_head);
                    m_head = (m_head + 1) % DEPTH;
                    m_cnt--;
                end
                if (wr_ok) begin
                    if (m_cnt == DEPTH) begin
                        m_head = (m_head + 1) % DEPTH;
                        m_cnt--;
                    end
                    m_write((m_head + m_cnt) % DEPTH, d);
                    m_cnt++;
                end
            end
        end else begin
            e_err = (op != 2'b00);
        end
    endtask

    task automatic compare();
        bit qm;
        qm = (m_mode >= 1) && (m_mode <= 3);
        chk("dout_valid", 32'(dout_valid), 32'(e_dv));
        chk("err", 32'(err), 32'(e_err));
        chk("count", 32'(count), 32'(m_cnt));
        chk("full", 32'(full), 32'(qm && m_cnt == DEPTH));
        chk("empty", 32'(empty), 32'(qm && m_cnt == 0));
        if (e_known) chk("dout", Dout, e_dout);
    endtask

    task automatic cycle(input logic r, input logic [2:0] md, input logic [2:0] ce,
                         input logic [1:0] op, input logic [DW-1:0] d, input logic [2:0] a);
        reset = r; mode_in = md; chip_en = ce; rw = op; Din = d; addr = a;
        model_step(r, md, ce, op, d, a);
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [2:0] md;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_mode = 0; m_head = 0; m_cnt = 0;
        e_dout = '0; e_known = 1'b1; e_dv = 1'b0; e_err = 1'b0;

        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0);
        chk("rst_dout", Dout, 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_empty", 32'(empty), 32'h0);
        chk("rst_full", 32'(full), 32'h0);

        // FIFO fill, overflow, drain
        cycle(0, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) cycle(0, 1, 1, 2'b01, 32'(i * 32'h11), 0);
        chk("fifo_full", 32'(full), 32'h1);
        chk("fifo_cnt8", 32'(count), 32'h8);
        cycle(0, 1, 1, 2'b01, 32'h99, 0);
        chk("fifo_ovf_err", 32'(err), 32'h1);
        chk("fifo_ovf_cnt", 32'(count), 32'h8);
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 1, 1, 2'b10, 0, 0);
            chk("fifo_rd_data", Dout, 32'(i * 32'h11));
            chk("fifo_rd_valid", 32'(dout_valid), 32'h1);
        end
        chk("fifo_empty", 32'(empty), 32'h1);

        // LIFO
        cycle(0, 2, 1, 0, 0, 0);
        cycle(0, 2, 1, 2'b01, 32'hA, 0);
        cycle(0, 2, 1, 2'b01, 32'hB, 0);
        cycle(0, 2, 1, 2'b01, 32'hC, 0);
        cycle(0, 2, 1, 2'b10, 0, 0);
        chk("lifo_pop_c", Dout, 32'hC);
        cycle(0, 2, 1, 2'b11, 32'hD, 0);
        chk("lifo_rdwr_b", Dout, 32'hB);
        chk("lifo_rdwr_cnt", 32'(count), 32'h2);
        cycle(0, 2, 1, 2'b10, 0, 0);
        chk("lifo_pop_d", Dout, 32'hD);
        cycle(0, 2, 1, 2'b10, 0, 0);
        chk("lifo_pop_a", Dout, 32'hA);
        cycle(0, 2, 1, 2'b10, 0, 0);
        chk("lifo_unf_err", 32'(err), 32'h1);
        chk("lifo_unf_valid", 32'(dout_valid), 32'h0);

        // Ring overwrite
        cycle(0, 3, 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++) cycle(0, 3, 1, 2'b01, 32'(i), 0);
        chk("ring_cnt", 32'(count), 32'h8);
        chk("ring_no_err", 32'(err), 32'h0);
        for (int i = 2; i <= 9; i++) begin
            cycle(0, 3, 1, 2'b10, 0, 0);
            chk("ring_rd", Dout, 32'(i));
        end

        // RAM read-before-write
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 2'b01, 32'hDEAD_BEEF, 3'd5);
        cycle(0, 0, 1, 2'b11, 32'h1234, 3'd5);
        chk("ram_rbw", Dout, 32'hDEAD_BEEF);
        cycle(0, 0, 1, 2'b10, 0, 3'd5);
        chk("ram_rd", Dout, 32'h1234);
        chk("ram_full", 32'(full), 32'h0);
        chk("ram_empty", 32'(empty), 32'h0);

        // Chip select and mode-switch flush
        cycle(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 3'b010, 2'b01, 32'(i), 0);
        chk("cs_cnt", 32'(count), 32'h0);
        chk("cs_err", 32'(err), 32'h0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 2'b01, 32'(i + 5), 0);
        chk("pre_sw_cnt", 32'(count), 32'h4);
        cycle(0, 2, 1, 2'b01, 32'h77, 0);
        chk("sw_cnt", 32'(count), 32'h0);
        cycle(0, 2, 1, 2'b00, 0, 0);
        chk("sw_wr_ignored", 32'(count), 32'h0);

        // Reset during a read
        cycle(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 2'b01, 32'(i + 32'h40), 0);
        cycle(1, 1, 1, 2'b10, 0, 0);
        chk("rrd_valid", 32'(dout_valid), 32'h0);
        chk("rrd_count", 32'(count), 32'h0);
        chk("rrd_dout", Dout, 32'h0);

        // Randomized traffic
        md = 3'd1;
        for (int n = 0; n < 4000; n++) begin
            logic       r;
            logic [2:0] ce;
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 9) < 8) md = 3'($urandom_range(0, 3));
                else                          md = 3'($urandom_range(4, 7));
            end
            r  = ($urandom_range(0, 149) == 0);
            ce = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b001;
            cycle(r, md, ce, 2'($urandom_range(0, 3)), $urandom, 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
